// File: rtl/paralelo_a_serial_param.sv
//------------------------------------------------------------------------------
// paralelo_a_serial_param
//
// Parallel-to-serial symbol transmitter. A continuous serial stream is sent on
// `out`, one bit per clk32f cycle, as back-to-back WIDTH-bit symbols:
//   - COM_SYM  while the link is inactive,
//   - data     from a one-entry holding buffer while active and the buffer is full,
//   - IDLE_SYM while active and the buffer is empty.
// The symbol is chosen only at a symbol boundary (load edge). The inputs are
// sampled there and held in a shift register, so later input changes cannot
// alter the symbol already being sent.
//
// Parameters
//   WIDTH      symbol width in bits (4..32)
//   COM_SYM    symbol sent while inactive
//   IDLE_SYM   symbol sent while active with no data buffered
//   LSB_FIRST  0 = MSB transmitted first, 1 = LSB transmitted first
//
// Ports
//   clk32f     in   serial bit clock; all state updates on its rising edge
//   reset      in   synchronous, active-high reset
//   active     in   link active, sampled at symbol boundaries only
//   in_valid   in   in_data holds a symbol offered for transmission
//   in_data    in   parallel data symbol [WIDTH-1:0]
//   in_ready   out  holding buffer can accept a symbol (registered)
//   out        out  registered serial bit stream
//   sym_start  out  high during the first bit of every symbol
//   sym_type   out  type of symbol on out: 00 COM, 01 IDLE, 10 DATA
//------------------------------------------------------------------------------
module paralelo_a_serial_param #(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] COM_SYM   = WIDTH'(8'hBC),
  parameter logic [WIDTH-1:0] IDLE_SYM  = WIDTH'(8'h7C),
  parameter bit               LSB_FIRST = 1'b0
) (
  input  logic             clk32f,
  input  logic             reset,
  input  logic             active,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out,
  output logic             sym_start,
  output logic [1:0]       sym_type
);

  localparam int               CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    SYM_COM  = 2'b00,
    SYM_IDLE = 2'b01,
    SYM_DATA = 2'b10
  } sym_type_e;

  // Bit position within the current symbol; 0 marks the next edge as a load edge.
  logic [CNT_W-1:0] cnt;
  // Bits of the symbol in flight that are still to be sent, next bit at the
  // transmit end (MSB end or LSB end depending on LSB_FIRST).
  logic [WIDTH-1:0] shreg;
  sym_type_e        sym_type_q;

  // One-entry holding buffer.
  logic             buf_full;
  logic [WIDTH-1:0] buf_data;

  logic             load;
  logic             accept;
  logic             consume;
  logic             buf_full_next;
  logic [WIDTH-1:0] next_sym;
  sym_type_e        next_type;

  // Reset has priority inside the sequential block, so cnt == 0 alone is
  // enough here; the first edge after reset is a load edge because reset
  // leaves cnt at 0.
  assign load    = (cnt == '0);
  assign accept  = in_valid & in_ready;
  // The buffer is only drained by a load edge that actually sends it.
  assign consume = load & active & buf_full;

  // A buffer that is full keeps in_ready low, so accept and consume can never
  // coincide; a symbol accepted on a load edge waits for the next one.
  assign buf_full_next = accept | (buf_full & ~consume);

  // Symbol selection, evaluated with the buffer state from before the edge.
  always_comb begin
    // NOTE: every output of an always_comb gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    next_sym  = IDLE_SYM;
    next_type = SYM_IDLE;
    if (!active) begin
      next_sym  = COM_SYM;
      next_type = SYM_COM;
    end else if (buf_full) begin
      next_sym  = buf_data;
      next_type = SYM_DATA;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // right-hand side reads the value from before the edge, independent of
  // statement order.
  always_ff @(posedge clk32f) begin
    if (reset) begin
      cnt        <= '0;
      shreg      <= '0;
      out        <= 1'b0;
      sym_start  <= 1'b0;
      sym_type_q <= SYM_COM;
      buf_full   <= 1'b0;
      in_ready   <= 1'b0;
    end else begin
      if (load) begin
        out        <= LSB_FIRST ? next_sym[0] : next_sym[WIDTH-1];
        shreg      <= LSB_FIRST ? (next_sym >> 1) : (next_sym << 1);
        sym_start  <= 1'b1;
        sym_type_q <= next_type;
      end else begin
        out       <= LSB_FIRST ? shreg[0] : shreg[WIDTH-1];
        shreg     <= LSB_FIRST ? (shreg >> 1) : (shreg << 1);
        sym_start <= 1'b0;
      end

      cnt      <= (cnt == LAST) ? '0 : cnt + 1'b1;
      buf_full <= buf_full_next;
      in_ready <= ~buf_full_next;
    end
  end

  // NOTE: the buffer payload is deliberately not reset; buf_full qualifies
  // it, and clearing buf_full is what discards the buffered symbol.
  always_ff @(posedge clk32f) begin
    if (accept) begin
      buf_data <= in_data;
    end
  end

  assign sym_type = sym_type_q;

endmodule

// File: tb/tb_paralelo_a_serial_param.sv
//------------------------------------------------------------------------------
// tb_paralelo_a_serial_param
//
// Directed bench for paralelo_a_serial_param. Two instances share the same
// inputs: dut_m sends MSB first, dut_l sends LSB first. For an 8-bit symbol v,
// bit i of a symbol on out is v[7-i] for dut_m and v[i] for dut_l.
// Outputs are sampled 1 time unit after each rising edge, and inputs are
// changed at that same point, so they apply to the following edge.
//------------------------------------------------------------------------------
module tb_paralelo_a_serial_param;

  localparam logic [1:0] T_COM  = 2'b00;
  localparam logic [1:0] T_IDLE = 2'b01;
  localparam logic [1:0] T_DATA = 2'b10;

  logic       clk32f = 1'b0;
  logic       reset;
  logic       active;
  logic       in_valid;
  logic [7:0] in_data;

  logic       ready_m, out_m, start_m;
  logic [1:0] type_m;
  logic       ready_l, out_l, start_l;
  logic [1:0] type_l;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk32f = ~clk32f;

  paralelo_a_serial_param #(
    .WIDTH    (8),
    .LSB_FIRST(1'b0)
  ) dut_m (
    .clk32f   (clk32f),
    .reset    (reset),
    .active   (active),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (ready_m),
    .out      (out_m),
    .sym_start(start_m),
    .sym_type (type_m)
  );

  paralelo_a_serial_param #(
    .WIDTH    (8),
    .LSB_FIRST(1'b1)
  ) dut_l (
    .clk32f   (clk32f),
    .reset    (reset),
    .active   (active),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (ready_l),
    .out      (out_l),
    .sym_start(start_l),
    .sym_type (type_l)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk32f);
    #1;
  endtask

  task automatic check_ready(input string tag, input logic exp);
    check({tag, " ready_m"}, ready_m, exp);
    check({tag, " ready_l"}, ready_l, exp);
  endtask

  // Advance one edge and check bit i of symbol v on both instances.
  task automatic check_bit(input string tag, input int i, input logic [7:0] v,
                           input logic [1:0] typ);
    tick();
    check($sformatf("%s b%0d out_m", tag, i),   out_m,   v[7-i]);
    check($sformatf("%s b%0d out_l", tag, i),   out_l,   v[i]);
    check($sformatf("%s b%0d start_m", tag, i), start_m, (i == 0));
    check($sformatf("%s b%0d start_l", tag, i), start_l, (i == 0));
    check($sformatf("%s b%0d type_m", tag, i),  type_m,  typ);
    check($sformatf("%s b%0d type_l", tag, i),  type_l,  typ);
  endtask

  // Expects the next edge to be a load edge; inputs are left untouched.
  task automatic expect_symbol(input string tag, input logic [7:0] v,
                               input logic [1:0] typ);
    for (int i = 0; i < 8; i++) check_bit(tag, i, v, typ);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " out_m"},   out_m,   1'b0);
    check({tag, " out_l"},   out_l,   1'b0);
    check({tag, " start_m"}, start_m, 1'b0);
    check({tag, " type_m"},  type_m,  T_COM);
    check_ready(tag, 1'b0);
  endtask

  initial begin
    reset    = 1'b1;
    active   = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;

    // Reset held for three cycles.
    for (int c = 0; c < 3; c++) begin
      tick();
      check_reset_outputs($sformatf("rst c%0d", c));
    end

    // COM while inactive: 0xBC -> 1,0,1,1,1,1,0,0 (MSB first).
    reset = 1'b0;
    check_bit("com0", 0, 8'hBC, T_COM);
    check_ready("com0 after release", 1'b1);
    for (int i = 1; i < 8; i++) check_bit("com0", i, 8'hBC, T_COM);
    expect_symbol("com1", 8'hBC, T_COM);

    // IDLE while active with nothing buffered: 0x7C -> 0,1,1,1,1,1,0,0;
    // LSB first 0,0,1,1,1,1,1,0.
    active = 1'b1;
    expect_symbol("idle0", 8'h7C, T_IDLE);

    // Push 0xA5 mid-symbol and wiggle active between boundaries; the IDLE in
    // flight must not change.
    for (int i = 0; i < 8; i++) begin
      if (i == 3) begin
        in_valid = 1'b1;
        in_data  = 8'hA5;
      end
      if (i == 4) begin
        in_valid = 1'b0;
        in_data  = 8'h00;
      end
      if (i == 5) active = 1'b0;
      if (i == 7) active = 1'b1;
      check_bit("idle1", i, 8'h7C, T_IDLE);
      if (i == 3) check_ready("push a5", 1'b0);
      if (i == 5) check_ready("a5 held", 1'b0);
    end
    // 0xA5 -> 1,0,1,0,0,1,0,1.
    check_bit("data_a5", 0, 8'hA5, T_DATA);
    check_ready("a5 loaded", 1'b1);
    for (int i = 1; i < 8; i++) check_bit("data_a5", i, 8'hA5, T_DATA);
    expect_symbol("idle2", 8'h7C, T_IDLE);

    // Back-pressure: 0x3C accepted on a load edge goes out one symbol later,
    // with IDLE in between; 0xC3 waits behind it.
    in_valid = 1'b1;
    in_data  = 8'h3C;
    for (int i = 0; i < 8; i++) begin
      check_bit("idle3", i, 8'h7C, T_IDLE);
      if (i == 0) begin
        check_ready("3c accepted", 1'b0);
        in_data = 8'hC3;
      end
    end
    // 0x3C -> 0,0,1,1,1,1,0,0. 0xC3 accepted on the edge after the load;
    // then 0xFF is offered but must be ignored.
    for (int i = 0; i < 8; i++) begin
      check_bit("data_3c", i, 8'h3C, T_DATA);
      if (i == 0) check_ready("3c loaded", 1'b1);
      if (i == 1) begin
        check_ready("c3 accepted", 1'b0);
        in_data = 8'hFF;
      end
    end
    in_valid = 1'b0;
    // 0xC3 -> 1,1,0,0,0,0,1,1, directly after 0x3C.
    expect_symbol("data_c3", 8'hC3, T_DATA);
    expect_symbol("idle4", 8'h7C, T_IDLE);

    // Inactive with data buffered: COM continues and 0x5A is held.
    active   = 1'b0;
    in_valid = 1'b1;
    in_data  = 8'h5A;
    for (int i = 0; i < 8; i++) begin
      check_bit("com2", i, 8'hBC, T_COM);
      if (i == 0) begin
        check_ready("5a accepted", 1'b0);
        in_valid = 1'b0;
        in_data  = 8'h00;
      end
    end
    expect_symbol("com3", 8'hBC, T_COM);
    check_ready("5a held inactive", 1'b0);

    // Reset on the edge that would send bit 4 of the next COM.
    for (int i = 0; i < 4; i++) check_bit("com4", i, 8'hBC, T_COM);
    reset = 1'b1;
    tick();
    check_reset_outputs("abort");

    // After release with active=1, the buffer must be empty: IDLE, not 0x5A.
    reset  = 1'b0;
    active = 1'b1;
    check_bit("idle5", 0, 8'h7C, T_IDLE);
    check_ready("after abort", 1'b1);
    for (int i = 1; i < 8; i++) check_bit("idle5", i, 8'h7C, T_IDLE);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
